// File: rtl/fpu_pkg.sv
// Shared types for the FPU arbiter: opcodes, arbiter states and per-opcode latencies.
package fpu_pkg;

    typedef enum logic [3:0] {
        FADD    = 4'd0,
        FSUB    = 4'd1,
        FMUL    = 4'd2,
        FDIV    = 4'd3,
        FSQRT   = 4'd4,
        FSGNJ   = 4'd5,
        FSGNJN  = 4'd6,
        FSGNJX  = 4'd7,
        FEQ     = 4'd8,
        FLT     = 4'd9,
        FLE     = 4'd10,
        FCVTWS  = 4'd11,
        FCVTSW  = 4'd12,
        OP_IDLE = 4'd15
    } fpu_op_t;

    // Opcodes from this value upward (13, 14, 15) are not executable requests.
    localparam logic [3:0] OP_ILLEGAL_MIN = 4'd13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Cycles from accept to the first resp_valid cycle.
    localparam int LAT_SGNJ  = 2;
    localparam int LAT_CVT   = 3;
    localparam int LAT_ARITH = 5;
    localparam int LAT_SQRT  = 9;
    localparam int LAT_DIV   = 12;

    function automatic int op_latency(input logic [3:0] op);
        case (op)
            FADD, FSUB, FMUL: return LAT_ARITH;
            FDIV:             return LAT_DIV;
            FSQRT:            return LAT_SQRT;
            FCVTWS, FCVTSW:   return LAT_CVT;
            default:          return LAT_SGNJ;
        endcase
    endfunction

endpackage

// File: rtl/fpu_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after prio wins.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] prio,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] pos;

    // Scan from lowest priority to highest so the last hit is the winner.
    always_comb begin
        gnt = '0;
        idx = '0;
        pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = IW'((int'(prio) + k) % N);
            if (req[pos]) begin
                gnt      = '0;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one multi-cycle FPU among NREQ requesters; round-robin grant, watchdog abort,
// tagged response channel.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int TAGW = 5,
    parameter int WDOG = 15
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*4-1:0]         req_op,
    input  logic [NREQ*32-1:0]        req_src0,
    input  logic [NREQ*32-1:0]        req_src1,
    input  logic [NREQ*TAGW-1:0]      req_tag,
    output logic [3:0]                fpu_op,
    output logic [31:0]               fpu_src0,
    output logic [31:0]               fpu_src1,
    input  logic [31:0]               fpu_result,
    input  logic                      fpu_fin,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [31:0]               resp_data,
    output logic [$clog2(NREQ)-1:0]   resp_id,
    output logic [TAGW-1:0]           resp_tag,
    output logic                      resp_err,
    output logic                      busy
);

    localparam int IDW = $clog2(NREQ);

    arb_state_t       state_reg;
    logic [IDW-1:0]   prio_reg;
    logic [3:0]       fpu_op_reg;
    logic [31:0]      src0_reg, src1_reg, resp_data_reg;
    logic [TAGW-1:0]  tag_reg;
    logic [IDW-1:0]   id_reg;
    logic             err_reg, resp_valid_reg;
    logic [7:0]       wdog_reg;

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;

    logic [3:0]       op_arr   [NREQ];
    logic [31:0]      src0_arr [NREQ];
    logic [31:0]      src1_arr [NREQ];
    logic [TAGW-1:0]  tag_arr  [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign op_arr[gi]   = req_op[gi*4 +: 4];
        assign src0_arr[gi] = req_src0[gi*32 +: 32];
        assign src1_arr[gi] = req_src1[gi*32 +: 32];
        assign tag_arr[gi]  = req_tag[gi*TAGW +: TAGW];
    end

    rr_arbiter #(.N(NREQ)) u_rr (
        .req  (req_valid),
        .prio (prio_reg),
        .gnt  (gnt),
        .idx  (gnt_idx)
    );

    assign req_ready  = (state_reg == IDLE) ? gnt : '0;
    assign busy       = (state_reg != IDLE);
    assign fpu_op     = fpu_op_reg;
    assign fpu_src0   = src0_reg;
    assign fpu_src1   = src1_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;
    assign resp_id    = id_reg;
    assign resp_tag   = tag_reg;
    assign resp_err   = err_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            prio_reg       <= '0;
            fpu_op_reg     <= OP_IDLE;
            src0_reg       <= '0;
            src1_reg       <= '0;
            tag_reg        <= '0;
            id_reg         <= '0;
            err_reg        <= 1'b0;
            wdog_reg       <= '0;
            resp_data_reg  <= '0;
            resp_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req_valid) begin
                        fpu_op_reg <= op_arr[gnt_idx];
                        src0_reg   <= src0_arr[gnt_idx];
                        src1_reg   <= src1_arr[gnt_idx];
                        tag_reg    <= tag_arr[gnt_idx];
                        id_reg     <= gnt_idx;
                        err_reg    <= (op_arr[gnt_idx] >= OP_ILLEGAL_MIN);
                        wdog_reg   <= '0;
                        prio_reg   <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                        state_reg  <= BUSY;
                    end
                end
                BUSY: begin
                    if (fpu_fin) begin
                        resp_data_reg  <= err_reg ? 32'd0 : fpu_result;
                        fpu_op_reg     <= OP_IDLE;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= RESP;
                    end else if (wdog_reg == 8'(WDOG - 1)) begin
                        // OP_IDLE during FLUSH lets the FPU drop back to its idle state.
                        err_reg       <= 1'b1;
                        resp_data_reg <= '0;
                        fpu_op_reg    <= OP_IDLE;
                        state_reg     <= FLUSH;
                    end else begin
                        wdog_reg <= wdog_reg + 8'd1;
                    end
                end
                FLUSH: begin
                    resp_valid_reg <= 1'b1;
                    state_reg      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter: stub FPU, transaction-level reference model, literal checks.
module tb_fpu_arbiter;
    import fpu_pkg::*;

    localparam int NREQ = 2;
    localparam int TAGW = 5;
    localparam int WDOG = 15;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic [NREQ-1:0]      req_valid, req_ready;
    logic [NREQ*4-1:0]    req_op;
    logic [NREQ*32-1:0]   req_src0, req_src1;
    logic [NREQ*TAGW-1:0] req_tag;
    logic [3:0]           fpu_op;
    logic [31:0]          fpu_src0, fpu_src1, fpu_result;
    logic                 fpu_fin;
    logic                 resp_valid, resp_ready;
    logic [31:0]          resp_data;
    logic [0:0]           resp_id;
    logic [TAGW-1:0]      resp_tag;
    logic                 resp_err, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit stub_hang = 1'b0;
    int unsigned fpu_cnt = 0;

    fpu_arbiter #(.NREQ(NREQ), .TAGW(TAGW), .WDOG(WDOG)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src0(req_src0), .req_src1(req_src1), .req_tag(req_tag),
        .fpu_op(fpu_op), .fpu_src0(fpu_src0), .fpu_src1(fpu_src1),
        .fpu_result(fpu_result), .fpu_fin(fpu_fin),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_id(resp_id), .resp_tag(resp_tag), .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d, want finish", cyc);
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, want);
        end
    endtask

    // Single-precision <-> real for normal numbers and zero.
    function automatic real f2r(input logic [31:0] b);
        int e;
        logic [63:0] d;
        if (b[30:0] == 31'd0) return b[31] ? -0.0 : 0.0;
        e = int'(b[30:23]) - 127 + 1023;
        d = {b[31], e[10:0], b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpu_func(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            FADD:    return r2f(f2r(a) + f2r(b));
            FSUB:    return r2f(f2r(a) - f2r(b));
            FMUL:    return r2f(f2r(a) * f2r(b));
            FSGNJ:   return {b[31], a[30:0]};
            FSGNJN:  return {~b[31], a[30:0]};
            FSGNJX:  return {a[31] ^ b[31], a[30:0]};
            FEQ:     return {31'd0, a == b};
            default: return a ^ {b[15:0], b[31:16]} ^ 32'(op);
        endcase
    endfunction

    // Stub FPU: OP_IDLE holds the counter at 0 and reports fin; each op finishes after its latency.
    always @(posedge clk) begin
        if (!rstn || fpu_op == OP_IDLE) fpu_cnt <= 0;
        else fpu_cnt <= fpu_cnt + 1;
    end

    always_comb begin
        fpu_fin = 1'b0;
        if (fpu_op == OP_IDLE || fpu_op >= OP_ILLEGAL_MIN) fpu_fin = 1'b1;
        else if (stub_hang && fpu_op == FDIV) fpu_fin = 1'b0;
        else fpu_fin = (fpu_cnt == 32'(op_latency(fpu_op) - 2));
    end
    assign fpu_result = fpu_func(fpu_op, fpu_src0, fpu_src1);

    // Reference model: one outstanding transaction with its accept cycle and response cycle.
    bit          started = 1'b0, after_rst = 1'b0, m_act = 1'b0;
    int          m_prio = 0, m_acc, m_resp_cyc, m_drive_end, m_id;
    logic [3:0]  m_op;
    logic [31:0] m_s0, m_s1, m_data;
    logic [TAGW-1:0] m_tag;
    bit          m_err;

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        int w;
        bit drv, bad, hang;
        exp_rdy = '0;
        w = -1;
        if (!m_act)
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && req_valid[(m_prio + k) % NREQ]) w = (m_prio + k) % NREQ;
        if (w >= 0) exp_rdy[w] = 1'b1;

        if (started) begin
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(m_act));
            if (!m_act) begin
                chk("idle_fpu_op", 32'(fpu_op), 32'(OP_IDLE));
                chk("idle_resp_valid", 32'(resp_valid), 32'd0);
                if (after_rst) begin
                    chk("rst_resp_data", resp_data, 32'd0);
                    chk("rst_resp_id", 32'(resp_id), 32'd0);
                    chk("rst_resp_tag", 32'(resp_tag), 32'd0);
                    chk("rst_resp_err", 32'(resp_err), 32'd0);
                    chk("rst_fpu_src0", fpu_src0, 32'd0);
                    chk("rst_fpu_src1", fpu_src1, 32'd0);
                end
            end else begin
                drv = (cyc > m_acc) && (cyc <= m_drive_end);
                chk("fpu_op", 32'(fpu_op), drv ? 32'(m_op) : 32'(OP_IDLE));
                if (drv) begin
                    chk("fpu_src0", fpu_src0, m_s0);
                    chk("fpu_src1", fpu_src1, m_s1);
                end
                chk("resp_valid", 32'(resp_valid), 32'(cyc >= m_resp_cyc));
                if (cyc >= m_resp_cyc) begin
                    chk("resp_data", resp_data, m_data);
                    chk("resp_id", 32'(resp_id), 32'(m_id));
                    chk("resp_tag", 32'(resp_tag), 32'(m_tag));
                    chk("resp_err", 32'(resp_err), 32'(m_err));
                end
            end
        end

        if (!rstn) begin
            started = 1'b1;
            m_act = 1'b0;
            m_prio = 0;
            after_rst = 1'b1;
        end else if (started) begin
            if (!m_act && w >= 0) begin
                m_act  = 1'b1;
                m_acc  = cyc;
                m_id   = w;
                m_op   = req_op[w*4 +: 4];
                m_s0   = req_src0[w*32 +: 32];
                m_s1   = req_src1[w*32 +: 32];
                m_tag  = req_tag[w*TAGW +: TAGW];
                bad    = (m_op >= OP_ILLEGAL_MIN);
                hang   = stub_hang && (m_op == FDIV);
                m_err  = bad || hang;
                m_data = m_err ? 32'd0 : fpu_func(m_op, m_s0, m_s1);
                m_resp_cyc  = hang ? cyc + WDOG + 2 : cyc + (bad ? LAT_SGNJ : op_latency(m_op));
                m_drive_end = hang ? cyc + WDOG : m_resp_cyc - 1;
                m_prio = (w + 1) % NREQ;
                after_rst = 1'b0;
            end else if (m_act && cyc >= m_resp_cyc && resp_ready) begin
                $display("txn id=%0d op=%0d tag=%0d data=%08h err=%0d lat=%0d",
                         resp_id, m_op, resp_tag, resp_data, resp_err, cyc - m_acc);
                m_act = 1'b0;
            end
        end
    end

    // Stimulus helpers
    task automatic drive_req(input int id, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [TAGW-1:0] t);
        req_op[id*4 +: 4]        = op;
        req_src0[id*32 +: 32]    = a;
        req_src1[id*32 +: 32]    = b;
        req_tag[id*TAGW +: TAGW] = t;
        req_valid[id]            = 1'b1;
    endtask

    task automatic wait_accept(input int id, output int acc);
        acc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_ready[id] && req_valid[id]) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_req(input int id);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_resp(input int acc, output int lat, output logic [31:0] d, output logic e);
        lat = -1;
        d = '0;
        e = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = cyc - acc;
                d = resp_data;
                e = resp_err;
                break;
            end
        end
    endtask

    localparam int NT = 7;
    logic [3:0]  t_op  [NT] = '{FSUB, FMUL, FEQ, FCVTWS, FSQRT, FLT, 4'd13};
    logic [31:0] t_a   [NT] = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h12345678,
                                32'h40800000, 32'hC0000000, 32'h3F800000};
    logic [31:0] t_b   [NT] = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h0,
                                32'h0, 32'h3F800000, 32'h3F800000};
    int          t_lat [NT] = '{5, 5, 2, 3, 9, 2, 2};
    logic [31:0] t_dat [NT] = '{32'h3F800000, 32'h40C00000, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
    bit          t_dck [NT] = '{1, 1, 1, 0, 0, 0, 1};

    initial begin
        int acc, lat, g, seen;
        int grants [4];
        logic [31:0] d;
        logic e;
        req_valid = '0; req_op = '0; req_src0 = '0; req_src1 = '0; req_tag = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // fsgnj: resp at cycle 2
        drive_req(0, FSGNJ, 32'h3F800000, 32'h80000000, 5'd3);
        wait_accept(0, acc);
        release_req(0);
        wait_resp(acc, lat, d, e);
        chk("sgnj_lat", 32'(lat), 32'd2);
        chk("sgnj_data", d, 32'hBF800000);
        chk("sgnj_err", 32'(e), 32'd0);
        @(posedge clk); #1;

        // fadd 1.0 + 2.0: resp at cycle 5
        drive_req(1, FADD, 32'h3F800000, 32'h40000000, 5'd9);
        wait_accept(1, acc);
        release_req(1);
        wait_resp(acc, lat, d, e);
        chk("fadd_lat", 32'(lat), 32'd5);
        chk("fadd_data", d, 32'h40400000);
        @(posedge clk); #1;

        for (int i = 0; i < NT; i++) begin
            drive_req(i % NREQ, t_op[i], t_a[i], t_b[i], 5'(i + 10));
            wait_accept(i % NREQ, acc);
            release_req(i % NREQ);
            wait_resp(acc, lat, d, e);
            chk("table_lat", 32'(lat), 32'(t_lat[i]));
            if (t_dck[i]) chk("table_data", d, t_dat[i]);
            chk("table_err", 32'(e), 32'(t_op[i] >= OP_ILLEGAL_MIN));
            @(posedge clk); #1;
        end

        // Backpressure after fdiv, with requester 1 waiting
        resp_ready = 1'b0;
        drive_req(0, FDIV, 32'h41200000, 32'h40000000, 5'd21);
        wait_accept(0, acc);
        release_req(0);
        drive_req(1, FMUL, 32'h40000000, 32'h40000000, 5'd22);
        wait_resp(acc, lat, d, e);
        chk("fdiv_lat", 32'(lat), 32'd12);
        seen = cyc;
        repeat (6) @(posedge clk);
        #1 resp_ready = 1'b1;
        wait_accept(1, acc);
        chk("bp_idle_next", 32'(acc), 32'(seen + 7));
        release_req(1);
        wait_resp(acc, lat, d, e);
        chk("bp_fmul_data", d, 32'h40800000);
        @(posedge clk); #1;

        // Watchdog: stub never finishes op 3
        stub_hang = 1'b1;
        drive_req(1, FDIV, 32'h3F800000, 32'h3F800000, 5'd30);
        wait_accept(1, acc);
        release_req(1);
        wait_resp(acc, lat, d, e);
        chk("wdog_lat", 32'(lat), 32'(WDOG + 2));
        chk("wdog_err", 32'(e), 32'd1);
        chk("wdog_data", d, 32'd0);
        @(posedge clk); #1;
        stub_hang = 1'b0;

        // Reset in cycle 4 of an fdiv
        drive_req(0, FDIV, 32'h40000000, 32'h3F800000, 5'd7);
        wait_accept(0, acc);
        release_req(0);
        while (cyc != acc + 4) begin
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("rst_no_resp", 32'(seen), 32'd0);

        // Contention right after reset: prio starts at 0
        @(posedge clk); #1;
        drive_req(0, FMUL, 32'h40000000, 32'h40400000, 5'd1);
        drive_req(1, FMUL, 32'h40400000, 32'h40400000, 5'd2);
        g = 0;
        for (int i = 0; i < 100 && g < 4; i++) begin
            @(negedge clk);
            if (|(req_ready & req_valid)) begin
                grants[g] = req_ready[1] ? 1 : 0;
                g++;
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        chk("cont_count", 32'(g), 32'd4);
        chk("cont_g0", 32'(grants[0]), 32'd0);
        chk("cont_g1", 32'(grants[1]), 32'd1);
        chk("cont_g2", 32'(grants[2]), 32'd0);
        chk("cont_g3", 32'(grants[3]), 32'd1);
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        chk("final_idle", 32'(busy), 32'd0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
